nibble_serial_mult_ctrl: RTL



---
 rtl/nibble_serial_mult_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/nibble_serial_mult_ctrl.sv
// Nibble-serial sequencer around the external registered 9x4 multiplier: issues B one nibble per cycle,
// shift-accumulates the tagged products into a 9+4*NIBBLES result. Optional: NIBBLE_MULT_ZERO_SKIP_EN.
module nibble_serial_mult_ctrl #(
    parameter int NIBBLES     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8:0]             in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    output logic [8:0]             mul_x,
    output logic [3:0]             mul_y,
    input  logic [12:0]            mul_product,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [9+4*NIBBLES-1:0] result
);
    localparam int BW = 4 * NIBBLES;
    localparam int RW = 9 + BW;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] NIB_C    = CW'(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_d;

    logic [8:0]    a_reg;
    logic [BW-1:0] b_reg, b_shift;
    logic [RW-1:0] acc, acc_sum;
    logic [CW-1:0] issue_cnt;
    logic          accept, issuing, acc_last, zero_op;

    // Tag pipe mirrors the multiplier's register stages so each product knows its nibble weight.
    logic [MUL_LATENCY:1] vld_pipe;
    logic [IW-1:0]        tag_pipe [MUL_LATENCY:1];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign issuing   = (state == RUN) && (issue_cnt < NIB_C);
    assign b_shift   = b_reg >> {issue_cnt, 2'b00};
    assign mul_y     = issuing ? b_shift[3:0] : 4'h0;
    assign mul_x     = a_reg;
    assign acc_sum   = acc + ({{(RW-13){1'b0}}, mul_product} << {tag_pipe[MUL_LATENCY], 2'b00});
    assign acc_last  = vld_pipe[MUL_LATENCY] && (tag_pipe[MUL_LATENCY] == LAST_IDX);

`ifdef NIBBLE_MULT_ZERO_SKIP_EN
    assign zero_op = (in_a == 9'd0) || (in_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept)    state_d = zero_op ? DONE : RUN;
            RUN:     if (acc_last)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            result    <= '0;
            issue_cnt <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            acc       <= '0;
            issue_cnt <= '0;
            if (zero_op) result <= '0;
        end else if (state == RUN) begin
            if (issuing)               issue_cnt <= issue_cnt + CW'(1);
            if (vld_pipe[MUL_LATENCY]) acc       <= acc_sum;
            if (acc_last)              result    <= acc_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= MUL_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= issuing;
            tag_pipe[1] <= issue_cnt[IW-1:0];
            for (int i = 2; i <= MUL_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end
endmodule
